// File: rtl/fp_pkg.sv
// Shared IEEE 754 single-precision types and constants for the FP adder datapath.
package fp_pkg;

    localparam int FP_BIAS         = 127;
    localparam int FP_EXP_W        = 8;
    localparam int FP_MANT_W       = 23;
    localparam int INT2FP_EXP_BASE = 158;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational leading-zero counter; an all-zero input counts as 32.
module lzc32 (
    input  logic [31:0] din,
    output logic [5:0]  cnt
);

    // Ascending scan: the highest set bit is the last to write cnt.
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (din[i]) cnt = 6'(31 - i);
        end
    end

endmodule

// File: rtl/int_to_fp_pipe.sv
// Pipelined int32 -> IEEE SP converter, one result per cycle, done 3 edges after capture.
// INT2FP_RNE_EN selects round-to-nearest-even; default build truncates toward zero.
module int_to_fp_pipe
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        _go,
    input  logic [31:0] Number,
    output logic [31:0] Result,
    output logic        done
);

    localparam int STAGES = 3;

    logic [STAGES:1] vld_pipe;

    logic        s1_sign;
    logic [31:0] s1_mag;

    logic        s2_sign;
    logic [31:0] s2_mag;
    logic [5:0]  s2_lz;
    logic        s2_zero;
    logic [5:0]  lz;

    logic        s3_sign;
    logic [31:0] s3_norm;
    logic [8:0]  s3_exp;
    logic        s3_zero;

    fp32_t                res_q;
    fp32_t                res_d;
    logic [FP_MANT_W-1:0] mant_r;
    logic [8:0]           exp_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:1], _go};
    end

    // 0x80000000 negates to itself, which is already the right magnitude.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sign <= 1'b0;
            s1_mag  <= '0;
        end else if (_go) begin
            s1_sign <= Number[31];
            s1_mag  <= Number[31] ? -Number : Number;
        end
    end

    lzc32 u_lzc (
        .din (s1_mag),
        .cnt (lz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_sign <= 1'b0;
            s2_mag  <= '0;
            s2_lz   <= '0;
            s2_zero <= 1'b0;
        end else if (vld_pipe[1]) begin
            s2_sign <= s1_sign;
            s2_mag  <= s1_mag;
            s2_lz   <= lz;
            s2_zero <= (s1_mag == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_sign <= 1'b0;
            s3_norm <= '0;
            s3_exp  <= '0;
            s3_zero <= 1'b0;
        end else if (vld_pipe[2]) begin
            s3_sign <= s2_sign;
            s3_norm <= s2_mag << s2_lz;
            s3_exp  <= 9'(INT2FP_EXP_BASE) - {3'b000, s2_lz};
            s3_zero <= s2_zero;
        end
    end

`ifdef INT2FP_RNE_EN
    logic       g_bit;
    logic       s_bit;
    logic       rnd_inc;
    logic       rnd_carry;
    always_comb begin
        g_bit   = s3_norm[7];
        s_bit   = |s3_norm[6:0];
        rnd_inc = g_bit & (s_bit | s3_norm[8]);
        {rnd_carry, mant_r} = {1'b0, s3_norm[30:8]} + 24'(rnd_inc);
        // Mantissa wrapped to zero: value rolled into the next binade.
        exp_r   = s3_exp + 9'(rnd_carry);
    end
`else
    always_comb begin
        mant_r = s3_norm[30:8];
        exp_r  = s3_exp;
    end
`endif

    always_comb begin
        res_d = '0;
        if (!s3_zero) begin
            res_d.sign = s3_sign;
            res_d.exp  = exp_r[FP_EXP_W-1:0];
            res_d.mant = mant_r;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= vld_pipe[STAGES];
            if (vld_pipe[STAGES]) res_q <= res_d;
        end
    end

    assign Result = res_q;

endmodule

// File: doc/int_to_fp_pipe.md
# int_to_fp_pipe

Pipelined signed-32-bit-integer to IEEE 754 single-precision converter. It is the operand-producing end of the FP adder datapath: integer values from control and test logic enter here, and IEEE SP words leave, ready for the adder's `Number1`/`Number2` inputs. Throughput is one conversion per cycle with a fixed 3-cycle latency and a `done` strobe aligned to `Result`.

## Interface
Parameters:
- None. Widths are fixed: int32 in, IEEE SP (S 31, Exp 30:23, Mantissa 22:0) out.

Ports:
- `clk`  in  1  Single clock; all state on rising edge.
- `reset`  in  1  Asynchronous, active-high. Clears all state.
- `_go`  in  1  Qualifies `Number` this cycle; one conversion accepted per high cycle.
- `Number`  in  32  Signed two's-complement integer.
- `Result`  out  32  IEEE SP encoding of the accepted `Number`.
- `done`  out  1  One-cycle pulse: `Result` is valid this cycle.

## Operation
- **Stage 1 (capture):**
  - sign = `Number[31]`.
  - mag = sign ? −`Number` : `Number`, as 32-bit unsigned. `0x80000000` yields mag `0x80000000`, which is correct.
  - Register sign, mag and valid = `_go`.
- **Stage 2 (normalize count):**
  - lz = leading-zero count of mag, range 0..32.
  - zero flag = (mag == 0).
  - Register sign, mag, lz, zero, valid.
- **Stage 3 (shift, round, pack):**
  - norm = mag << lz (bit 31 set unless zero).
  - exp = 158 − lz (bias 127 + 31). Arithmetic is 9 bits; the value never exceeds 158.
  - mant = norm[30:8], guard G = norm[7], sticky S = |norm[6:0].
  - Rounding is set by the configuration below.
  - Round carry-out (mant all ones + 1): mant = 0, exp = exp + 1.
  - Zero flag set: `Result` = `0x00000000` (positive zero), whatever the sign.
  - `Result` = {sign, exp[7:0], mant}.
- Overflow, NaN, infinity and denormals cannot arise from int32 input; no handling exists for them.
- Output registers are updated only when the stage-3 valid is high. `Result` holds its last value otherwise.

## Timing
- **Latency:** `_go` high at edge N → `done` high and `Result` valid in the cycle after edge N+3 (three register stages).
- **Throughput:** back-to-back `_go` is fully pipelined. There is no stall, backpressure or bubble.
- **Valid tracking:** a 3-bit valid shift register. Data registers in each stage are enabled by the previous stage's valid.
- **`done`:** exactly one pulse per accepted input, in order. `_go` low produces no pulse.
- **Reset values:** `Result` = `0x00000000`, `done` = 0, all valid bits 0.
- **Reset mid-operation:** all in-flight conversions are dropped, and no `done` follows for them. The first `_go` after deassertion behaves as from power-up.
- **`_go` during reset:** ignored.

## Configuration
- Macro `INT2FP_RNE_EN`:
  - **Defined:** round-to-nearest-even. Increment mant when G & (S | mant[0]). Round carry-out is handled as in Stage 3.
  - **Undefined:** truncation (round toward zero). G and S are ignored and no carry-out can occur. The exp-increment path is compiled out.

## Structure
- Shared package `fp_pkg`:
  - typedef `fp32_t` (packed struct: sign, exp[7:0], mant[22:0]).
  - constants `FP_BIAS` = 127, `FP_EXP_W` = 8, `FP_MANT_W` = 23, `INT2FP_EXP_BASE` = 158.
  - The adder and this block both use it.
- One sub-module, `lzc32`:
  - combinational leading-zero counter, 32-bit in, 6-bit count out.
  - returns 32 for all-zero input.
  - instantiated in stage 2.

## Test plan
- **Basic conversions**, each with `_go` for one cycle: 1 → `0x3F800000`; −1 (`0xFFFFFFFF`) → `0xBF800000`; 0 → `0x00000000`. `done` pulses exactly 3 cycles after each `_go`.
- **Extremes:** `0x80000000` → `0xCF000000` in both builds. `0x7FFFFFFF` → `0x4F000000` with `INT2FP_RNE_EN`, `0x4EFFFFFF` without.
- **Ties:**

  | Input | With `INT2FP_RNE_EN` | Without |
  |---|---|---|
  | 16777217 | `0x4B800000` (tie to even, down) | `0x4B800000` |
  | 16777219 | `0x4B800002` (tie, odd, up) | `0x4B800001` |

- **Streaming:** 1, 2, 3 … 8 on consecutive cycles with `_go` held high. Eight consecutive `done` pulses, in order, starting 3 cycles later; 8 → `0x41000000`.
- **Sparse input:** `_go` pattern 1,0,1,0 with values 5, X, −5, X → `done` pattern 1,0,1,0 carrying `0x40A00000` then `0xC0A00000`. `Result` holds `0x40A00000` in the idle cycle.
- **Reset mid-flight:**
  - Issue 3 conversions, then assert `reset` asynchronously between edges one cycle later.
  - `done` = 0 and `Result` = 0 immediately; no `done` after release.
  - A new 7 → `0x40E00000` three cycles after its `_go`.
